// File: rtl/score_title_drawer.sv
// score_title_drawer
// Keeps a 4-digit BCD player score (saturating at 9999), absorbs score-add
// requests into a pending counter that drains one point per clock, and
// renders the frame-latched score as 8x16 glyphs with a registered
// scoreDR/scoreRGB output.
// Optional feature macro: SCORE_BLANK_LEADING_ZEROS_EN (blank leading zero
// digits of the displayed value; the LSD is always drawn).
//
// Request semantics: addScore is a one-clock request with no backpressure;
// addValue is taken in the cycle addScore=1 and merged into the pending
// counter. scoreBusy is status only and never blocks a request.
module score_title_drawer #(
  parameter logic [10:0] TOP_LEFT_X  = 11'd40,
  parameter logic [10:0] TOP_LEFT_Y  = 11'd24,
  parameter logic [7:0]  DIGIT_COLOR = 8'hFF,
  parameter logic [9:0]  PENDING_MAX = 10'd1023
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        addScore,
  input  logic [7:0]  addValue,
  input  logic        clearScore,
  output logic        scoreDR,
  output logic [7:0]  scoreRGB,
  output logic        scoreBusy,
  output logic [1:0]  fsm_state,
  output logic [15:0] score_digits
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNT     = 2'd1,
    SATURATED = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [15:0] score, score_next, score_inc;
  logic [9:0]  pending, pending_next;
  logic [10:0] pending_sum;
  logic [15:0] disp;

  // BCD +1 with carry ripple; 9 wraps to 0 and carries upward.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Font ROM: 16 rows x 8 bits per glyph, row 0 in the top byte, bit 7 = left.
  function automatic logic [127:0] glyph_bits(input logic [3:0] d);
    case (d)
      4'd0:    glyph_bits = 128'h00_00_FF_81_81_81_81_81_81_81_81_81_81_81_FF_00;
      4'd1:    glyph_bits = 128'h00_00_01_01_01_01_01_01_01_01_01_01_01_01_01_00;
      4'd2:    glyph_bits = 128'h00_00_FF_01_01_01_01_01_FF_80_80_80_80_80_FF_00;
      4'd3:    glyph_bits = 128'h00_00_FF_01_01_01_01_01_FF_01_01_01_01_01_FF_00;
      4'd4:    glyph_bits = 128'h00_00_81_81_81_81_81_81_FF_01_01_01_01_01_01_00;
      4'd5:    glyph_bits = 128'h00_00_FF_80_80_80_80_80_FF_01_01_01_01_01_FF_00;
      4'd6:    glyph_bits = 128'h00_00_FF_80_80_80_80_80_FF_81_81_81_81_81_FF_00;
      4'd7:    glyph_bits = 128'h00_00_FF_01_01_01_01_01_01_01_01_01_01_01_01_00;
      4'd8:    glyph_bits = 128'h00_00_FF_81_81_81_81_81_FF_81_81_81_81_81_FF_00;
      4'd9:    glyph_bits = 128'h00_00_FF_81_81_81_81_81_FF_01_01_01_01_01_FF_00;
      default: glyph_bits = 128'h0;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state, score and pending logic; clearScore overrides everything.
  always_comb begin
    state_next   = state;
    score_next   = score;
    pending_next = pending;
    score_inc    = bcd_inc(score);
    pending_sum  = 11'd0;
    case (state)
      IDLE: begin
        if (addScore && (addValue != 8'd0)) begin
          pending_sum  = {3'd0, addValue};
          pending_next = (pending_sum > {1'b0, PENDING_MAX}) ? PENDING_MAX : pending_sum[9:0];
          state_next   = COUNT;
        end
      end
      COUNT: begin
        score_next   = score_inc;
        pending_sum  = {1'b0, pending} + (addScore ? {3'd0, addValue} : 11'd0) - 11'd1;
        pending_next = (pending_sum > {1'b0, PENDING_MAX}) ? PENDING_MAX : pending_sum[9:0];
        if (score_inc == 16'h9999) begin
          pending_next = 10'd0;
          state_next   = SATURATED;
        end else if (pending_next == 10'd0) begin
          state_next = IDLE;
        end
      end
      SATURATED: begin
        pending_next = 10'd0;
      end
      default: begin
        state_next   = IDLE;
        pending_next = 10'd0;
      end
    endcase
    if (clearScore) begin
      score_next   = 16'h0000;
      pending_next = 10'd0;
      state_next   = IDLE;
    end
  end

  // Score, pending counter, busy flag and per-frame display latch.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      score     <= 16'h0000;
      pending   <= 10'd0;
      scoreBusy <= 1'b0;
      disp      <= 16'h0000;
    end else begin
      score     <= score_next;
      pending   <= pending_next;
      scoreBusy <= (pending_next != 10'd0);
      if (startOfFrame) disp <= score;
    end
  end

  // Render decode: region test, digit select, glyph pixel lookup.
  logic [10:0]  dx, dy;
  logic         in_region, blank, lit;
  logic [1:0]   idx;
  logic [3:0]   digit;
  logic [127:0] glyph;
  logic [7:0]   row_bits;

  always_comb begin
    dx        = pixelX - TOP_LEFT_X;
    dy        = pixelY - TOP_LEFT_Y;
    in_region = (pixelX >= TOP_LEFT_X) && (dx[10:5] == 6'd0) &&
                (pixelY >= TOP_LEFT_Y) && (dy[10:4] == 7'd0);
    idx       = dx[4:3];
    case (idx)
      2'd0:    digit = disp[15:12];
      2'd1:    digit = disp[11:8];
      2'd2:    digit = disp[7:4];
      default: digit = disp[3:0];
    endcase
`ifdef SCORE_BLANK_LEADING_ZEROS_EN
    case (idx)
      2'd0:    blank = (disp[15:12] == 4'd0);
      2'd1:    blank = (disp[15:8] == 8'd0);
      2'd2:    blank = (disp[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    glyph    = glyph_bits(digit);
    row_bits = glyph[{~dy[3:0], 3'b000} +: 8];
    lit      = in_region && !blank && row_bits[~dx[2:0]];
  end

  // Registered draw request and colour, one clock after the pixel.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      scoreDR  <= 1'b0;
      scoreRGB <= 8'h00;
    end else begin
      scoreDR  <= lit;
      scoreRGB <= lit ? DIGIT_COLOR : 8'h00;
    end
  end

  assign fsm_state    = state;
  assign score_digits = score;

endmodule

// File: tb/tb_score_title_drawer.sv
// Directed bench for score_title_drawer: hand-computed scores, states and
// glyph pixels, compared through one checking task.
module tb_score_title_drawer;

  localparam logic [10:0] TLX = 11'd40;
  localparam logic [10:0] TLY = 11'd24;
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_COUNT = 2'd1;
  localparam logic [1:0]  ST_SAT   = 2'd2;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX, pixelY;
  logic        addScore;
  logic [7:0]  addValue;
  logic        clearScore;
  logic        scoreDR;
  logic [7:0]  scoreRGB;
  logic        scoreBusy;
  logic [1:0]  fsm_state;
  logic [15:0] score_digits;

  int n_checks = 0;
  int n_pass   = 0;
  logic [8:0] exp_q[$];

  score_title_drawer dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .pixelX       (pixelX),
    .pixelY       (pixelY),
    .addScore     (addScore),
    .addValue     (addValue),
    .clearScore   (clearScore),
    .scoreDR      (scoreDR),
    .scoreRGB     (scoreRGB),
    .scoreBusy    (scoreBusy),
    .fsm_state    (fsm_state),
    .score_digits (score_digits)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_add(input logic [7:0] v);
    addScore = 1'b1;
    addValue = v;
    tick(1);
    addScore = 1'b0;
    addValue = 8'd0;
  endtask

  task automatic pulse_clear();
    clearScore = 1'b1;
    tick(1);
    clearScore = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (scoreBusy && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, scoreBusy, 1'b0);
  endtask

  task automatic add_wait(input logic [7:0] v);
    pulse_add(v);
    wait_idle("drain", 1100);
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick(1);
    startOfFrame = 1'b0;
  endtask

  // Present a pixel, expect the registered result one clock later.
  task automatic probe(input string tag, input logic [10:0] x, input logic [10:0] y,
                       input logic exp_dr);
    logic [8:0] exp;
    pixelX = x;
    pixelY = y;
    exp_q.push_back({exp_dr, exp_dr ? 8'hFF : 8'h00});
    tick(1);
    exp = exp_q.pop_front();
    check(tag, {scoreDR, scoreRGB}, exp);
  endtask

  logic lz_shown;

  initial begin
`ifdef SCORE_BLANK_LEADING_ZEROS_EN
    lz_shown = 1'b0;
`else
    lz_shown = 1'b1;
`endif
    resetN = 1'b0; startOfFrame = 1'b0; pixelX = 11'd0; pixelY = 11'd0;
    addScore = 1'b0; addValue = 8'd0; clearScore = 1'b0;
    tick(3);
    check("rst_dr", scoreDR, 1'b0);
    check("rst_rgb", scoreRGB, 8'h00);
    check("rst_busy", scoreBusy, 1'b0);
    check("rst_state", fsm_state, ST_IDLE);
    check("rst_score", score_digits, 16'h0000);
    resetN = 1'b1;
    tick(1);

    // Frame with "0000": glyph pixels and region boundaries.
    frame();
    probe("z_d3_row2", TLX + 11'd24, TLY + 11'd2, 1'b1);
    probe("z_d0_row2", TLX, TLY + 11'd2, lz_shown);
    probe("z_d3_row0", TLX + 11'd24, TLY, 1'b0);
    probe("z_d3_row5c3", TLX + 11'd27, TLY + 11'd5, 1'b0);
    probe("z_x31_in", TLX + 11'd31, TLY + 11'd5, 1'b1);
    probe("z_x32_out", TLX + 11'd32, TLY + 11'd5, 1'b0);
    probe("z_xm1_out", TLX - 11'd1, TLY + 11'd5, 1'b0);
    probe("z_y16_out", TLX + 11'd24, TLY + 11'd16, 1'b0);
    probe("z_origin", 11'd0, 11'd0, 1'b0);

    // Add 25: busy next clock, 25 counts, display updates only on frame.
    addScore = 1'b1; addValue = 8'd25;
    tick(1);
    addScore = 1'b0; addValue = 8'd0;
    check("a25_busy", scoreBusy, 1'b1);
    check("a25_state", fsm_state, ST_COUNT);
    tick(24);
    check("a25_busy24", scoreBusy, 1'b1);
    check("a25_score24", score_digits, 16'h0024);
    tick(1);
    check("a25_score", score_digits, 16'h0025);
    check("a25_idle", fsm_state, ST_IDLE);
    check("a25_done", scoreBusy, 1'b0);
    probe("a25_old_d3", TLX + 11'd31, TLY + 11'd5, 1'b1);
    frame();
    probe("a25_new_d3", TLX + 11'd31, TLY + 11'd5, 1'b0);
    probe("a25_new_d3l", TLX + 11'd24, TLY + 11'd5, 1'b1);
    probe("a25_new_d2", TLX + 11'd16, TLY + 11'd5, 1'b0);

    // Overlapping adds: 10 then 5 three clocks later.
    pulse_clear();
    check("clr_score", score_digits, 16'h0000);
    pulse_add(8'd10);
    tick(2);
    pulse_add(8'd5);
    wait_idle("ovl_drain", 100);
    check("ovl_score", score_digits, 16'h0015);

    // Carry ripple 0099 -> 0100.
    pulse_clear();
    add_wait(8'd99);
    check("c99", score_digits, 16'h0099);
    add_wait(8'd1);
    check("c100", score_digits, 16'h0100);

    // "0042" rendering, with or without leading-zero blanking.
    pulse_clear();
    add_wait(8'd42);
    check("s42", score_digits, 16'h0042);
    frame();
    probe("s42_d0", TLX, TLY + 11'd2, lz_shown);
    probe("s42_d1", TLX + 11'd8, TLY + 11'd8, lz_shown);
    probe("s42_d2", TLX + 11'd16, TLY + 11'd2, 1'b1);
    probe("s42_d3r", TLX + 11'd31, TLY + 11'd5, 1'b1);
    probe("s42_d3l", TLX + 11'd24, TLY + 11'd5, 1'b0);

    // Saturation at 9999.
    pulse_clear();
    for (int i = 0; i < 39; i++) add_wait(8'd255);
    add_wait(8'd45);
    check("s9990", score_digits, 16'h9990);
    pulse_add(8'd200);
    wait_idle("sat_drain", 50);
    check("sat_score", score_digits, 16'h9999);
    check("sat_state", fsm_state, ST_SAT);
    pulse_add(8'd50);
    tick(3);
    check("sat_hold", score_digits, 16'h9999);
    check("sat_busy", scoreBusy, 1'b0);
    check("sat_state2", fsm_state, ST_SAT);
    pulse_clear();
    check("sat_clr", score_digits, 16'h0000);
    check("sat_clr_st", fsm_state, ST_IDLE);

    // clearScore wins over a same-cycle addScore.
    add_wait(8'd3);
    clearScore = 1'b1; addScore = 1'b1; addValue = 8'd7;
    tick(1);
    clearScore = 1'b0; addScore = 1'b0; addValue = 8'd0;
    check("cw_score", score_digits, 16'h0000);
    check("cw_busy", scoreBusy, 1'b0);
    check("cw_state", fsm_state, ST_IDLE);
    tick(3);
    check("cw_hold", score_digits, 16'h0000);

    // Reset mid-count drops pending points.
    pulse_add(8'd200);
    tick(10);
    check("mid_score", score_digits, 16'h0010);
    resetN = 1'b0;
    #1;
    check("mr_busy", scoreBusy, 1'b0);
    check("mr_score", score_digits, 16'h0000);
    tick(2);
    resetN = 1'b1;
    tick(5);
    check("mr_after", score_digits, 16'h0000);
    check("mr_state", fsm_state, ST_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
